// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: control-flow enums and the prediction queue entry type.
package branch_resolve_unit_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {CFLOW_PCPLUS4, CFLOW_BRANCH, CFLOW_JAL, CFLOW_JALR} cflow_mode_t;
    typedef enum logic [2:0] {BEQ, BNE, BLT, BGE, BLTU, BGEU} branch_mode_t;
    typedef enum logic [1:0] {CFHINT_NONE, CFHINT_CALL, CFHINT_RET, CFHINT_OTHER} cflow_hint_t;
    typedef struct packed {
        logic            pred_taken;
        logic [XLEN-1:0] pc_pred;
    } pred_entry_t;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch prediction, EX issue and resolve result signals of the resolve unit.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    import branch_resolve_unit_pkg::*;
    logic            flush;
    logic            pq_push;
    logic            pq_pred_taken;
    logic [XLEN-1:0] pq_pc_pred;
    logic            pq_ready;
    logic            ex_fire;
    cflow_mode_t     cflow_mode_in;
    branch_mode_t    branch_mode_in;
    cflow_hint_t     cflow_hint_in;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] target_in;
    logic [XLEN-1:0] pc_seq_in;
    logic            resolve_valid;
    cflow_mode_t     cflow_mode;
    cflow_hint_t     cflow_hint;
    logic            cflow_taken;
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;
    logic            pq_err;
    logic [CNT_W-1:0] perf_cflow_cnt;
    logic [CNT_W-1:0] perf_miss_cnt;
    modport master (
        output flush, pq_push, pq_pred_taken, pq_pc_pred, ex_fire, cflow_mode_in,
               branch_mode_in, cflow_hint_in, in_a, in_b, target_in, pc_seq_in,
        input  pq_ready, resolve_valid, cflow_mode, cflow_hint, cflow_taken, mispredict,
               redirect_pc, pq_err, perf_cflow_cnt, perf_miss_cnt
    );
    modport slave (
        input  flush, pq_push, pq_pred_taken, pq_pc_pred, ex_fire, cflow_mode_in,
               branch_mode_in, cflow_hint_in, in_a, in_b, target_in, pc_seq_in,
        output pq_ready, resolve_valid, cflow_mode, cflow_hint, cflow_taken, mispredict,
               redirect_pc, pq_err, perf_cflow_cnt, perf_miss_cnt
    );
endinterface

// File: rtl/branch_resolve_unit_pred_queue.sv
// branch_resolve_unit_pred_queue: in-order FIFO of fetch predictions with push/pop/clear.
module branch_resolve_unit_pred_queue
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  pred_entry_t            din,
    output pred_entry_t            dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    pred_entry_t mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem[rptr_q];
    // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = clear ? '0 : wptr_q + AW'(do_push);
        rptr_d  = clear ? '0 : rptr_q + AW'(do_pop);
        count_d = clear ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    // Entry storage; contents of free slots are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr_q] <= din;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches/jumps against queued fetch predictions and drives redirects.
// Define BRANCH_PERF_EN to enable the saturating resolve/mispredict counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    branch_resolve_unit_if.slave bus
);
    import branch_resolve_unit_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    pred_entry_t pq_din, pq_head;
    logic [CW-1:0] pq_count;
    logic pq_full, pq_empty, pq_push, pq_pop, pq_clear, fire, cond, taken, mis;
    logic [XLEN-1:0] target;
    logic valid_q, valid_d, taken_q, taken_d, pt_q, pt_d, err_q, err_d;
    cflow_mode_t mode_q, mode_d;
    cflow_hint_t hint_q, hint_d;
    logic [XLEN-1:0] rpc_q, rpc_d, ppc_q, ppc_d;

    assign mis = valid_q && (taken_q != pt_q || (taken_q && ppc_q != rpc_q));

    // A flush or a live mispredict squashes EX and discards wrong-path predictions.
    always_comb begin
        pq_clear = bus.flush || mis;
        fire     = bus.ex_fire && !pq_clear;
        pq_pop   = fire && (bus.cflow_mode_in != CFLOW_PCPLUS4);
        pq_push  = bus.pq_push && !pq_full && !pq_clear;
        pq_din   = '{pred_taken: bus.pq_pred_taken, pc_pred: bus.pq_pc_pred};
    end

    // Actual direction and aligned target of the instruction in EX.
    always_comb begin
        cond = 1'b0;
        case (bus.branch_mode_in)
            BEQ:     cond = bus.in_a == bus.in_b;
            BNE:     cond = bus.in_a != bus.in_b;
            BLT:     cond = $signed(bus.in_a) < $signed(bus.in_b);
            BGE:     cond = $signed(bus.in_a) >= $signed(bus.in_b);
            BLTU:    cond = bus.in_a < bus.in_b;
            BGEU:    cond = bus.in_a >= bus.in_b;
            default: cond = 1'b0;
        endcase
        target = {bus.target_in[XLEN-1:1], 1'b0};
        taken  = (bus.cflow_mode_in == CFLOW_BRANCH) ? cond : (bus.cflow_mode_in != CFLOW_PCPLUS4);
    end

    // Result register inputs; cycles without a resolved cflow instr load reset values.
    always_comb begin
        valid_d = pq_pop;
        mode_d  = pq_pop ? bus.cflow_mode_in : CFLOW_PCPLUS4;
        hint_d  = pq_pop ? bus.cflow_hint_in : CFHINT_NONE;
        taken_d = pq_pop && taken;
        rpc_d   = !pq_pop ? '0 : taken ? target : bus.pc_seq_in;
        pt_d    = pq_pop && !pq_empty && pq_head.pred_taken;
        ppc_d   = (pq_pop && !pq_empty) ? pq_head.pc_pred : '0;
        err_d   = err_q || (pq_pop && pq_empty);
    end

    // Result and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= CFLOW_PCPLUS4;
            hint_q  <= CFHINT_NONE;
            taken_q <= 1'b0;
            rpc_q   <= '0;
            pt_q    <= 1'b0;
            ppc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            hint_q  <= hint_d;
            taken_q <= taken_d;
            rpc_q   <= rpc_d;
            pt_q    <= pt_d;
            ppc_q   <= ppc_d;
            err_q   <= err_d;
        end
    end

    branch_resolve_unit_pred_queue #(.DEPTH(DEPTH)) u_pq (
        .clk(clk), .rst(rst), .clear(pq_clear), .push(pq_push), .pop(pq_pop),
        .din(pq_din), .dout(pq_head), .full(pq_full), .empty(pq_empty), .count(pq_count)
    );

    assign bus.pq_ready      = pq_count < CW'(DEPTH);
    assign bus.resolve_valid = valid_q;
    assign bus.cflow_mode    = mode_q;
    assign bus.cflow_hint    = hint_q;
    assign bus.cflow_taken   = taken_q;
    assign bus.mispredict    = mis;
    assign bus.redirect_pc   = rpc_q;
    assign bus.pq_err        = err_q;

`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] cfl_q, cfl_d, miss_q, miss_d;
    // Saturating event counters over presented results.
    always_comb begin
        cfl_d  = cfl_q + CNT_W'(valid_q && !(&cfl_q));
        miss_d = miss_q + CNT_W'(mis && !(&miss_q));
    end
    // Counter registers, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfl_q  <= '0;
            miss_q <= '0;
        end else begin
            cfl_q  <= cfl_d;
            miss_q <= miss_d;
        end
    end
    assign bus.perf_cflow_cnt = cfl_q;
    assign bus.perf_miss_cnt  = miss_q;
`else
    assign bus.perf_cflow_cnt = '0;
    assign bus.perf_miss_cnt  = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + random stimulus, reference model feeding a cycle scoreboard.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;
`ifdef BRANCH_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif
    localparam int DEPTH = 4;

    typedef struct {
        bit push; bit pt; logic [31:0] ppc;
        bit fire; cflow_mode_t mode; branch_mode_t bm; cflow_hint_t hint;
        logic [31:0] a; logic [31:0] b; logic [31:0] tgt; logic [31:0] seq;
        bit flush; bit rst;
    } stim_t;
    typedef struct {
        bit valid; cflow_mode_t mode; cflow_hint_t hint; bit taken; bit mis;
        logic [31:0] rpc; bit ready; bit err; logic [CNT_W-1:0] pc; logic [CNT_W-1:0] pm;
    } exp_t;
    typedef struct { bit t; logic [31:0] pc; } pred_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(CNT_W)) bus();
    branch_resolve_unit #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    pred_t mq[$];
    exp_t sb[$];
    exp_t cur;
    bit merr;
    bit mon_en = 0;
    int errors = 0;
    int checks = 0;

    function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
        end
    endfunction

    function automatic exp_t reset_out();
        exp_t e;
        e.valid = 0; e.mode = CFLOW_PCPLUS4; e.hint = CFHINT_NONE; e.taken = 0; e.mis = 0;
        e.rpc = 0; e.ready = 1; e.err = 0; e.pc = 0; e.pm = 0;
        return e;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v, input bit inc);
        return (inc && v != {CNT_W{1'b1}}) ? v + 1'b1 : v;
    endfunction

    function automatic bit ref_cond(input branch_mode_t m, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb2;
        sa = a; sb2 = b;
        if (m == BEQ) return a == b;
        if (m == BNE) return a != b;
        if (m == BLT) return sa < sb2;
        if (m == BGE) return !(sa < sb2);
        if (m == BLTU) return a < b;
        return !(a < b);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.push = 0; s.pt = 0; s.ppc = 0; s.fire = 0; s.mode = CFLOW_PCPLUS4; s.bm = BEQ;
        s.hint = CFHINT_NONE; s.a = 0; s.b = 0; s.tgt = 0; s.seq = 0; s.flush = 0; s.rst = 0;
        return s;
    endfunction

    function automatic stim_t push_s(input bit pt, input logic [31:0] ppc);
        stim_t s;
        s = idle(); s.push = 1; s.pt = pt; s.ppc = ppc;
        return s;
    endfunction

    function automatic stim_t fire_s(input cflow_mode_t m, input branch_mode_t bm, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] tgt, input logic [31:0] seq);
        stim_t s;
        s = idle(); s.fire = 1; s.mode = m; s.bm = bm; s.a = a; s.b = b; s.tgt = tgt; s.seq = seq;
        s.hint = CFHINT_CALL;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t nx;
        pred_t p;
        bit rdy;
        logic [31:0] t;
        @(posedge clk);
        #1;
        bus.pq_push = s.push; bus.pq_pred_taken = s.pt; bus.pq_pc_pred = s.ppc;
        bus.ex_fire = s.fire; bus.cflow_mode_in = s.mode; bus.branch_mode_in = s.bm;
        bus.cflow_hint_in = s.hint; bus.in_a = s.a; bus.in_b = s.b; bus.target_in = s.tgt;
        bus.pc_seq_in = s.seq; bus.flush = s.flush; rst = s.rst;
        nx = reset_out();
        if (s.rst) begin
            mq.delete();
            merr = 0;
            cur = reset_out();
            sb.delete();
            sb.push_back(cur);
        end else begin
`ifdef BRANCH_PERF_EN
            nx.pc = sat(cur.pc, cur.valid);
            nx.pm = sat(cur.pm, cur.mis);
`endif
            if (s.flush || cur.mis) mq.delete();
            else begin
                rdy = mq.size() < DEPTH;
                if (s.fire && s.mode != CFLOW_PCPLUS4) begin
                    if (mq.size() == 0) begin
                        p.t = 0; p.pc = 0; merr = 1;
                    end else p = mq.pop_front();
                    t = s.tgt & 32'hFFFF_FFFE;
                    nx.valid = 1; nx.mode = s.mode; nx.hint = s.hint;
                    nx.taken = (s.mode == CFLOW_BRANCH) ? ref_cond(s.bm, s.a, s.b) : 1'b1;
                    nx.rpc = nx.taken ? t : s.seq;
                    nx.mis = (nx.taken != p.t) || (nx.taken && p.pc != t);
                end
                if (s.push && rdy) begin
                    p.t = s.pt; p.pc = s.ppc;
                    mq.push_back(p);
                end
            end
        end
        nx.ready = mq.size() < DEPTH;
        nx.err = merr;
        cur = nx;
        sb.push_back(nx);
    endtask

    // Monitor: compares the presented DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("resolve_valid", 64'(bus.resolve_valid), 64'(e.valid));
                chk("cflow_mode", 64'(bus.cflow_mode), 64'(e.mode));
                chk("cflow_hint", 64'(bus.cflow_hint), 64'(e.hint));
                chk("cflow_taken", 64'(bus.cflow_taken), 64'(e.taken));
                chk("mispredict", 64'(bus.mispredict), 64'(e.mis));
                chk("redirect_pc", 64'(bus.redirect_pc), 64'(e.rpc));
                chk("pq_ready", 64'(bus.pq_ready), 64'(e.ready));
                chk("pq_err", 64'(bus.pq_err), 64'(e.err));
                chk("perf_cflow_cnt", 64'(bus.perf_cflow_cnt), 64'(e.pc));
                chk("perf_miss_cnt", 64'(bus.perf_miss_cnt), 64'(e.pm));
            end
        end
    end

    initial begin
        stim_t s;
        s = idle();
        bus.pq_push = 0; bus.pq_pred_taken = 0; bus.pq_pc_pred = 0; bus.ex_fire = 0;
        bus.cflow_mode_in = CFLOW_PCPLUS4; bus.branch_mode_in = BEQ; bus.cflow_hint_in = CFHINT_NONE;
        bus.in_a = 0; bus.in_b = 0; bus.target_in = 0; bus.pc_seq_in = 0; bus.flush = 0;
        merr = 0;
        cur = reset_out();
        sb.push_back(cur);
        mon_en = 1;
        s.rst = 1;
        step(s);
        step(s);
        step(idle());
        // correctly predicted taken BEQ
        step(push_s(1, 32'h100));
        step(fire_s(CFLOW_BRANCH, BEQ, 5, 5, 32'h100, 32'h40));
        step(idle());
        // signed BLT taken, predicted not taken
        step(push_s(0, 0));
        step(fire_s(CFLOW_BRANCH, BLT, 32'hFFFF_FFFF, 1, 32'h200, 32'h44));
        step(push_s(1, 32'h111));
        step(idle());
        // unsigned BGEU not taken, predicted taken
        step(push_s(1, 32'h300));
        step(fire_s(CFLOW_BRANCH, BGEU, 1, 2, 32'h300, 32'h48));
        step(idle());
        step(idle());
        // fill to DEPTH, overflow push dropped, push+pop while full and while not full
        for (int i = 0; i < 5; i++) step(push_s(1, 32'h100));
        s = fire_s(CFLOW_JAL, BEQ, 0, 0, 32'h101, 32'h4);
        s.push = 1; s.pt = 1; s.ppc = 32'h100;
        step(s);
        step(s);
        step(idle());
        // drain, then JALR on the empty queue
        s = idle(); s.flush = 1;
        step(s);
        step(fire_s(CFLOW_JALR, BEQ, 0, 0, 32'h501, 32'h8));
        step(idle());
        step(push_s(1, 32'h700));
        step(push_s(0, 0));
        step(fire_s(CFLOW_BRANCH, BNE, 3, 3, 32'h20, 32'h10));
        s = idle(); s.rst = 1;
        step(s);
        step(idle());
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.push = $urandom_range(0, 1) == 1;
            s.pt = $urandom_range(0, 1) == 1;
            s.ppc = $urandom_range(0, 1) == 1 ? 32'h100 : 32'h200;
            s.fire = $urandom_range(0, 9) < 6;
            s.mode = cflow_mode_t'($urandom_range(0, 3));
            s.bm = branch_mode_t'($urandom_range(0, 5));
            s.hint = cflow_hint_t'($urandom_range(0, 3));
            s.a = $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 3));
            s.b = $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 3));
            s.tgt = $urandom_range(0, 1) == 1 ? 32'h100 : 32'h201;
            s.seq = $urandom;
            s.flush = $urandom_range(0, 99) < 3;
            s.rst = $urandom_range(0, 199) == 0;
            step(s);
        end
        step(idle());
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
